// File: rtl/ai_board_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : ai_board_feeder
//  Purpose  : Tracks shots fired at the opponent (fired map, live-hit map,
//             alive-ship mask) and, on request, loads that state into the
//             density-search AI slave, starts a search and reads the target.
//  Revision : 1.0  initial release
// ============================================================================
module ai_board_feeder (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        new_game,
    input  logic        shot_valid,
    output logic        shot_ready,
    input  logic [6:0]  shot_index,
    input  logic        shot_hit,
    input  logic        shot_sunk,
    input  logic [2:0]  sunk_id,
    input  logic [6:0]  sunk_origin,
    input  logic        sunk_vert,
    input  logic        compute_req,
    output logic        busy,
    output logic [6:0]  target,
    output logic        target_valid,
    output logic [2:0]  avm_address,
    output logic        avm_write,
    output logic        avm_read,
    output logic [63:0] avm_writedata,
    input  logic [63:0] avm_readdata,
    input  logic        avm_waitrequest
);

    localparam logic [6:0] c_LAST_CELL = 7'd99;
    localparam logic [2:0] c_LAST_SHIP = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_W_FLO     = 4'd1,
        S_W_FHI     = 4'd2,
        S_W_HLO     = 4'd3,
        S_W_HHI     = 4'd4,
        S_W_SHIP    = 4'd5,
        S_W_GO      = 4'd6,
        S_WAIT_BUSY = 4'd7,
        S_WAIT_DONE = 4'd8,
        S_RD        = 4'd9
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [99:0] r_fired;
    logic [99:0] r_hits;
    logic [4:0]  r_alive;
    logic [99:0] w_fired_next;
    logic [99:0] w_hits_next;
    logic [4:0]  w_alive_next;

    logic        r_avm_write;
    logic        r_avm_read;
    logic [2:0]  r_avm_address;
    logic [63:0] r_avm_writedata;
    logic [6:0]  r_target;
    logic        r_target_valid;

    logic        w_write_next;
    logic        w_read_next;
    logic [2:0]  w_addr_next;
    logic [63:0] w_wdata_next;

    logic        w_idle;
    logic        w_idx_ok;
    logic        w_sink;
    logic [2:0]  w_len;
    logic [3:0]  w_origin_x;
    logic [7:0]  w_cell [5];
    logic [4:0]  w_cell_ok;
    logic [99:0] w_clear_mask;
    logic        w_unused_readdata;

    assign w_idle     = (r_state == S_IDLE);
    assign w_idx_ok   = (shot_index <= c_LAST_CELL);
    assign w_sink     = shot_hit && shot_sunk && (sunk_id <= c_LAST_SHIP);
    assign w_origin_x = 4'(sunk_origin % 7'd10);
    assign w_unused_readdata = &{1'b0, avm_readdata[63:7]};

    // Ship length by id; unknown ids have length 0 so they clear nothing.
    always_comb begin
        w_len = 3'd0;
        case (sunk_id)
            3'd0:    w_len = 3'd2;
            3'd1:    w_len = 3'd3;
            3'd2:    w_len = 3'd3;
            3'd3:    w_len = 3'd4;
            3'd4:    w_len = 3'd5;
            default: w_len = 3'd0;
        endcase
    end

    // Candidate cells of the sunk ship; horizontal runs must not wrap rows.
    for (genvar k = 0; k < 5; k++) begin : g_sink_cell
        assign w_cell[k]    = {1'b0, sunk_origin} + (sunk_vert ? 8'(10 * k) : 8'(k));
        assign w_cell_ok[k] = (3'(k) < w_len) && (w_cell[k] <= 8'd99) &&
                              (sunk_vert || (({4'd0, w_origin_x} + 8'(k)) <= 8'd9));
    end

    // Build the mask of hit cells that a sinking shot removes.
    always_comb begin
        w_clear_mask = '0;
        for (int k = 0; k < 5; k++) begin
            if (w_cell_ok[k]) begin
                w_clear_mask[w_cell[k][6:0]] = 1'b1;
            end
        end
    end

    // Next map state: new_game beats a shot; sink clearing beats the hit set.
    always_comb begin
        w_fired_next = r_fired;
        w_hits_next  = r_hits;
        w_alive_next = r_alive;
        if (w_idle) begin
            if (new_game) begin
                w_fired_next = '0;
                w_hits_next  = '0;
                w_alive_next = 5'b11111;
            end else if (shot_valid && w_idx_ok) begin
                w_fired_next[shot_index] = 1'b1;
                if (shot_hit) begin
                    w_hits_next[shot_index] = 1'b1;
                end
                if (w_sink) begin
                    w_alive_next[sunk_id] = 1'b0;
                    w_hits_next = w_hits_next & ~w_clear_mask;
                end
            end
        end
    end

    // Map registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fired <= '0;
            r_hits  <= '0;
            r_alive <= 5'b11111;
        end else begin
            r_fired <= w_fired_next;
            r_hits  <= w_hits_next;
            r_alive <= w_alive_next;
        end
    end

    // Query sequencing and the bus values for the state being entered.
    // Write data comes from the next-map values so a shot taken together
    // with compute_req is already reflected in the first write.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (compute_req)      w_state_next = S_W_FLO;
            S_W_FLO:     if (!avm_waitrequest) w_state_next = S_W_FHI;
            S_W_FHI:     if (!avm_waitrequest) w_state_next = S_W_HLO;
            S_W_HLO:     if (!avm_waitrequest) w_state_next = S_W_HHI;
            S_W_HHI:     if (!avm_waitrequest) w_state_next = S_W_SHIP;
            S_W_SHIP:    if (!avm_waitrequest) w_state_next = S_W_GO;
            S_W_GO:      if (!avm_waitrequest) w_state_next = S_WAIT_BUSY;
            S_WAIT_BUSY: if (avm_waitrequest)  w_state_next = S_WAIT_DONE;
            S_WAIT_DONE: if (!avm_waitrequest) w_state_next = S_RD;
            S_RD:        if (!avm_waitrequest) w_state_next = S_IDLE;
            default:                           w_state_next = S_IDLE;
        endcase

        w_write_next = 1'b0;
        w_read_next  = 1'b0;
        w_addr_next  = 3'd0;
        w_wdata_next = 64'd0;
        case (w_state_next)
            S_W_FLO: begin
                w_write_next = 1'b1;
                w_addr_next  = 3'd1;
                w_wdata_next = {14'd0, w_fired_next[49:0]};
            end
            S_W_FHI: begin
                w_write_next = 1'b1;
                w_addr_next  = 3'd2;
                w_wdata_next = {14'd0, w_fired_next[99:50]};
            end
            S_W_HLO: begin
                w_write_next = 1'b1;
                w_addr_next  = 3'd3;
                w_wdata_next = {14'd0, w_hits_next[49:0]};
            end
            S_W_HHI: begin
                w_write_next = 1'b1;
                w_addr_next  = 3'd4;
                w_wdata_next = {14'd0, w_hits_next[99:50]};
            end
            S_W_SHIP: begin
                w_write_next = 1'b1;
                w_addr_next  = 3'd5;
                w_wdata_next = {59'd0, w_alive_next};
            end
            S_W_GO: begin
                w_write_next = 1'b1;
                w_addr_next  = 3'd0;
            end
            S_RD: begin
                w_read_next  = 1'b1;
                w_addr_next  = 3'd0;
            end
            default: begin
                w_write_next = 1'b0;
            end
        endcase
    end

    // State, registered bus strobes and target capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_avm_write     <= 1'b0;
            r_avm_read      <= 1'b0;
            r_avm_address   <= 3'd0;
            r_avm_writedata <= 64'd0;
            r_target        <= 7'd0;
            r_target_valid  <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_avm_write     <= w_write_next;
            r_avm_read      <= w_read_next;
            r_avm_address   <= w_addr_next;
            r_avm_writedata <= w_wdata_next;
            r_target_valid  <= 1'b0;
            if ((r_state == S_RD) && !avm_waitrequest) begin
                r_target       <= avm_readdata[6:0];
                r_target_valid <= 1'b1;
            end
        end
    end

    assign shot_ready    = w_idle;
    assign busy          = !w_idle;
    assign target        = r_target;
    assign target_valid  = r_target_valid;
    assign avm_address   = r_avm_address;
    assign avm_write     = r_avm_write;
    assign avm_read      = r_avm_read;
    assign avm_writedata = r_avm_writedata;

endmodule
`default_nettype wire
